// File: rtl/sprite_scan_pkg.sv
// Shared types for the sprite line scanner: attribute field positions, scan FSM
// states, the height decode and the hit descriptor layout.
package sprite_scan_pkg;

    localparam int unsigned W1_Y_LSB     = 0;
    localparam int unsigned W1_VFLIP_BIT = 17;
    localparam int unsigned W1_Z_LSB     = 18;
    localparam int unsigned W1_HCODE_LSB = 30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_EVAL,
        ST_EMIT,
        ST_DONE
    } scan_state_e;

    typedef struct packed {
        logic [6:0]  idx;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [5:0]  row;
    } hit_desc_t;

    function automatic logic [6:0] sprite_height(input logic [1:0] code);
        return 7'd8 << code;
    endfunction

endpackage

// File: rtl/sprite_vis_check.sv
// Combinational visibility test of one sprite against a scanline; the
// subtraction wraps in 10 bits so sprites straddling line 0 work naturally.
module sprite_vis_check
    import sprite_scan_pkg::*;
(
    input  logic [9:0]  line_i,
    input  logic [31:0] w1_i,
    output logic        visible_o,
    output logic [5:0]  row_o
);

    logic [9:0] y;
    logic [9:0] delta;
    logic [9:0] height;
    logic [9:0] flipped;
    logic [1:0] z;
    logic       vflip;

    always_comb begin
        y         = w1_i[W1_Y_LSB +: 10];
        z         = w1_i[W1_Z_LSB +: 2];
        vflip     = w1_i[W1_VFLIP_BIT];
        height    = {3'b000, sprite_height(w1_i[W1_HCODE_LSB +: 2])};
        delta     = line_i - y;
        flipped   = height - 10'd1 - delta;
        visible_o = (z != 2'b00) && (delta < height);
        row_o     = vflip ? flipped[5:0] : delta[5:0];
    end

    logic unused_bits;
    assign unused_bits = ^{w1_i[29:20], w1_i[16:10], flipped[9:6]};

endmodule

// File: rtl/sprite_line_scanner.sv
// Per-scanline sprite scheduler: walks the attribute RAM and streams visible
// sprites to the renderer. Optional abort input under SPRITE_SCAN_ABORT_EN.
module sprite_line_scanner
    import sprite_scan_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 128,
    parameter int unsigned MAX_HITS    = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
`ifdef SPRITE_SCAN_ABORT_EN
    input  logic        abort_i,
`endif
    input  logic        start_i,
    input  logic [9:0]  line_i,
    output logic        rd_en_o,
    output logic [7:0]  rd_addr_o,
    input  logic [31:0] rd_data_i,
    output logic        hit_valid_o,
    input  logic        hit_ready_i,
    output logic [6:0]  hit_idx_o,
    output logic [31:0] hit_w0_o,
    output logic [31:0] hit_w1_o,
    output logic [5:0]  hit_row_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [6:0]  hit_cnt_o,
    output logic        overflow_o
);

    localparam logic [6:0] LAST_IDX = 7'(NUM_SPRITES - 1);
    localparam logic [6:0] MAX_C    = 7'(MAX_HITS);

    scan_state_e state_q, state_d;
    logic [6:0]  idx_q, idx_d;
    logic [9:0]  line_q, line_d;
    logic [31:0] w0_q, w0_d;
    hit_desc_t   desc_q, desc_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;

    logic        vis_hit;
    logic [5:0]  vis_row;

    sprite_vis_check u_vis (
        .line_i    (line_q),
        .w1_i      (rd_data_i),
        .visible_o (vis_hit),
        .row_o     (vis_row)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            line_q  <= '0;
            w0_q    <= '0;
            desc_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            line_q  <= line_d;
            w0_q    <= w0_d;
            desc_q  <= desc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        line_d  = line_q;
        w0_d    = w0_q;
        desc_d  = desc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RD0;
                    idx_d   = '0;
                    line_d  = line_i;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_RD0: state_d = ST_RD1;
            ST_RD1: begin
                w0_d    = rd_data_i;
                state_d = ST_EVAL;
            end
            // word1 arrives this cycle; a full hit budget means overflow
            ST_EVAL: begin
                if (vis_hit && cnt_q == MAX_C) begin
                    ovf_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (vis_hit) begin
                    desc_d  = '{idx: idx_q, w0: w0_q, w1: rd_data_i, row: vis_row};
                    state_d = ST_EMIT;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 7'd1;
                    state_d = ST_RD0;
                end
            end
            ST_EMIT: begin
                if (hit_ready_i) begin
                    cnt_d = cnt_q + 7'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 7'd1;
                        state_d = ST_RD0;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
`ifdef SPRITE_SCAN_ABORT_EN
        // abort wins over a simultaneous accept, so the count stays at what was taken
        if (abort_i && state_q != ST_IDLE && state_q != ST_DONE) begin
            state_d = ST_DONE;
            cnt_d   = cnt_q;
        end
`endif
    end

    assign rd_en_o     = (state_q == ST_RD0) || (state_q == ST_RD1);
    assign rd_addr_o   = {idx_q, (state_q == ST_RD1)};
    assign hit_valid_o = (state_q == ST_EMIT);
    assign hit_idx_o   = desc_q.idx;
    assign hit_w0_o    = desc_q.w0;
    assign hit_w1_o    = desc_q.w1;
    assign hit_row_o   = desc_q.row;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign hit_cnt_o   = cnt_q;
    assign overflow_o  = ovf_q;

endmodule

// File: doc/sprite_line_scanner.md
# sprite_line_scanner

Per-scanline sprite scheduler that owns the read port of the sprite attribute RAM. On each line-start request it walks all sprite entries in index order, decides which sprites intersect the requested line, and streams their attributes to the sprite renderer over a valid/ready handshake. It sits between the video timing generator and the sprite line renderer. The RAM write port stays with the bus side.

## Interface
- NUM_SPRITES, 128, entries scanned per line; each entry is two 32-bit words at 2i and 2i+1.
- MAX_HITS, 64, maximum sprites emitted per line.
- clk_i  in  1  single clock for the whole block.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  pulse: begin a scan for line_i; ignored while busy_o=1.
- line_i  in  10  scanline to test; sampled with start_i.
- rd_en_o  out  1  sprite RAM read enable.
- rd_addr_o  out  8  sprite RAM word address.
- rd_data_i  in  32  sprite RAM data; registered RAM, valid one cycle after the address.
- hit_valid_o  out  1  hit descriptor valid.
- hit_ready_i  in  1  renderer accepts the descriptor.
- hit_idx_o  out  7  sprite index.
- hit_w0_o, hit_w1_o  out  32 each  raw attribute words.
- hit_row_o  out  6  row within the sprite, vflip applied.
- busy_o  out  1  scan in progress.
- done_o  out  1  one-cycle pulse at scan end.
- hit_cnt_o  out  7  hits emitted in the last scan; held until the next start.
- overflow_o  out  1  more than MAX_HITS sprites were visible in the last scan; held until the next start.

## Operation
- Attribute fields:
  - w0: [11:0] addr, [15] mode, [25:16] x.
  - w1: [9:0] y, [16] hflip, [17] vflip, [19:18] z, [23:20] collision mask, [27:24] palette offset, [29:28] width code, [31:30] height code.
- Size decode: height = 8 << code, giving 8/16/32/64.
- A sprite is visible when z != 0 and delta < height.
  - delta = (line − y) mod 1024, computed in 10 bits so the y wrap is natural.
- hit_row_o = vflip ? height−1−delta : delta, truncated to 6 bits.
- FSM states:
  - IDLE –start_i→ RD0.
  - RD0 → RD1. Drives address 2i.
  - RD1 → EVAL. Drives address 2i+1; captures w0.
  - EVAL:
    - Word1 is on rd_data_i.
    - Visible and hit_cnt < MAX_HITS → load output registers, go to EMIT.
    - Visible and hit_cnt = MAX_HITS → set overflow_o, go to DONE.
    - Not visible → next sprite (RD0), or DONE after the last index.
  - EMIT:
    - hit_valid_o=1 until hit_ready_i; on the accept edge hit_cnt increments.
    - Then go to RD0 for the next sprite, or to DONE after the last index.
  - DONE → IDLE. done_o=1 for this one cycle.
- rd_en_o=1 only in RD0/RD1.
- start_i clears hit_cnt and overflow and latches line_i.

## Timing
- start_i sampled high at edge T → busy_o=1 and the RD0 address (0) presented from T+1.
- Per-sprite cost: invisible = 3 cycles; visible = 4 cycles plus backpressure.
- All-invisible scan of 128 sprites: done_o asserts 385 cycles after the start edge.
- Descriptor outputs are registered and stable while hit_valid_o=1 and hit_ready_i=0.
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
- Reset mid-scan: on the next edge, IDLE with all outputs 0. No done_o pulse is issued.
- start_i coincident with done_o: ignored.

## Configuration
- SPRITE_SCAN_ABORT_EN defined:
  - Adds input abort_i (1 bit).
  - abort_i high in any non-IDLE state → next state DONE; hit_valid_o drops; done_o pulses; hit_cnt_o keeps the accepted count.
- Undefined: no abort_i port; a scan always runs to completion.

## Structure
- Package sprite_scan_pkg holds:
  - Attribute field bit positions.
  - FSM state enum.
  - Height-decode function.
  - Descriptor struct (idx, w0, w1, row).
- Sub-module sprite_vis_check:
  - Combinational.
  - Inputs: line, w1.
  - Outputs: visible, row.
  - Instantiated once.

## Test plan
- Sprite 0: y=3, h=8, z=3; line 5 → one hit, idx 0, row 2, hit_cnt_o=1. Line 11 → zero hits, done_o only.
- y=1020, h=8, line 2 → hit, row 6. Same sprite with vflip=1 → row 1.
- z=0, y=3, line 3 → no hit. Sprites 5 and 9 visible → emitted in order 5, 9.
- MAX_HITS=4 with 6 visible sprites → exactly 4 emits, overflow_o=1, hit_cnt_o=4.
- hit_ready_i held low 10 cycles → descriptor stable, rd_en_o=0 throughout, single accept.
- rst_i during EMIT → next cycle all outputs 0 and no done_o. A new start_i then produces a full, correct scan.
